ad9361_rx_deframer: RTL and testbench

AD9361_RX_DEFRAMER -- requirements
Module: ad9361_rx_deframer

---
 rtl/ad9361_rx_pkg.sv | 18 +
 rtl/ad9361_rx_deframer_if.sv | 14 +
 rtl/ad9361_rx_lane.sv | 62 ++++++
 rtl/ad9361_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_ad9361_rx_deframer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9361_rx_pkg.sv
// rtl/ad9361_rx_pkg.sv - shared state enum and AD9361 data-bus field positions for the RX deframer
package ad9361_rx_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } rx_state_e;

  localparam int HALF_W    = 6;
  localparam int DIN_W     = 14;
  localparam int FRAME_BIT = 13;
  localparam int I_HI      = 12;
  localparam int I_LO      = 7;
  localparam int Q_HI      = 5;
  localparam int Q_LO      = 0;

endpackage

// File: rtl/ad9361_rx_deframer_if.sv
// rtl/ad9361_rx_deframer_if.sv - assembled I/Q sample bus leaving the deframer
interface ad9361_rx_deframer_if #(
  parameter int NUM_CH = 1,
  parameter int OUT_W  = 16
);

  logic [NUM_CH*OUT_W-1:0] rx_i;
  logic [NUM_CH*OUT_W-1:0] rx_q;
  logic                    rx_valid;

  modport master (output rx_i, output rx_q, output rx_valid);
  modport slave  (input  rx_i, input  rx_q, input  rx_valid);

endinterface

// File: rtl/ad9361_rx_lane.sv
// rtl/ad9361_rx_lane.sv - one channel's I/Q half-word capture, sample assembly and width extension
module ad9361_rx_lane
  import ad9361_rx_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int OUT_W    = 16,
  parameter int SIGN_EXT = 1
) (
  input  logic              ad9361_dclk,
  input  logic              sys_nrst,
  input  logic [HALF_W-1:0] i_half,
  input  logic [HALF_W-1:0] q_half,
  input  logic              msb_we,
  input  logic              lsb_we,
  input  logic              out_we,
  output logic [OUT_W-1:0]  rx_i,
  output logic [OUT_W-1:0]  rx_q
);

  logic [HALF_W-1:0]   i_msb;
  logic [HALF_W-1:0]   i_lsb;
  logic [HALF_W-1:0]   q_msb;
  logic [HALF_W-1:0]   q_lsb;
  logic [SAMPLE_W-1:0] i_smp;
  logic [SAMPLE_W-1:0] q_smp;

  function automatic logic [OUT_W-1:0] extend(input logic [SAMPLE_W-1:0] s);
    logic [OUT_W-1:0] r;
    r = {OUT_W{(SIGN_EXT != 0) & s[SAMPLE_W-1]}};
    r[SAMPLE_W-1:0] = s;
    return r;
  endfunction

  // The last channel's LSB arrives on the same beat the output is written, so bypass its register.
  assign i_smp = {i_msb, lsb_we ? i_half : i_lsb};
  assign q_smp = {q_msb, lsb_we ? q_half : q_lsb};

  always_ff @(posedge ad9361_dclk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      i_msb <= '0;
      i_lsb <= '0;
      q_msb <= '0;
      q_lsb <= '0;
      rx_i  <= '0;
      rx_q  <= '0;
    end else begin
      if (msb_we) begin
        i_msb <= i_half;
        q_msb <= q_half;
      end
      if (lsb_we) begin
        i_lsb <= i_half;
        q_lsb <= q_half;
      end
      if (out_we) begin
        rx_i <= extend(i_smp);
        rx_q <= extend(q_smp);
      end
    end
  end

endmodule

// File: rtl/ad9361_rx_deframer.sv
// rtl/ad9361_rx_deframer.sv - AD9361 RX frame alignment, lock tracking and sample output
// Define AD9361_RX_FRAME_ERR_EN to enable the frame_err strobe and frame_err_cnt counter.
module ad9361_rx_deframer
  import ad9361_rx_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int SAMPLE_W    = 12,
  parameter int OUT_W       = 16,
  parameter int SIGN_EXT    = 1,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                 ad9361_dclk,
  input  logic                 sys_nrst,
  input  logic [DIN_W-1:0]     ad9361_din,
  ad9361_rx_deframer_if.master rx,
  output logic                 locked,
  output logic                 frame_err,
  output logic [15:0]          frame_err_cnt
);

  localparam int BEATS  = 2 * NUM_CH;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int LAST   = BEATS - 1;
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  rx_state_e               state;
  rx_state_e               state_nxt;
  logic [GOOD_W-1:0]       good;
  logic [GOOD_W-1:0]       good_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [CNT_W-1:0]        beat_idx;
  logic                    frame_bit;
  logic                    frame_d;
  logic                    rise;
  logic                    exp_frame;
  logic                    mismatch;
  logic                    frame_done;
  logic                    out_we;
  logic                    err_evt;
  logic [NUM_CH*OUT_W-1:0] rx_i_w;
  logic [NUM_CH*OUT_W-1:0] rx_q_w;
  logic                    unused_din6;

  assign unused_din6 = ad9361_din[6];
  assign frame_bit   = ad9361_din[FRAME_BIT];
  assign rise        = frame_bit & ~frame_d;
  assign beat_idx    = rise ? '0 : cnt;
  // Mismatch is judged against the free-running count so an early FRAME rise is caught, not absorbed.
  assign exp_frame   = (int'(cnt) < NUM_CH);
  assign mismatch    = (state != UNLOCKED) && (frame_bit != exp_frame);
  assign frame_done  = (cnt == CNT_W'(LAST));
  assign cnt_nxt     = rise ? CNT_W'(1) : (frame_done ? '0 : cnt + CNT_W'(1));
  assign locked      = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    out_we    = 1'b0;
    err_evt   = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (rise) begin
          state_nxt = LOCKING;
          good_nxt  = '0;
        end
      end
      LOCKING: begin
        if (mismatch) begin
          state_nxt = UNLOCKED;
        end else if (frame_done) begin
          good_nxt = good + GOOD_W'(1);
          if (int'(good) + 1 >= LOCK_FRAMES) begin
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_nxt = UNLOCKED;
          err_evt   = 1'b1;
        end else if (frame_done) begin
          out_we = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge ad9361_dclk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state       <= UNLOCKED;
      good        <= '0;
      cnt         <= '0;
      frame_d     <= 1'b0;
      rx.rx_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      good        <= good_nxt;
      cnt         <= cnt_nxt;
      frame_d     <= frame_bit;
      rx.rx_valid <= out_we;
    end
  end

  // Channel c owns beats 2c (MSB) and 2c+1 (LSB) of each frame.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    ad9361_rx_lane #(
      .SAMPLE_W (SAMPLE_W),
      .OUT_W    (OUT_W),
      .SIGN_EXT (SIGN_EXT)
    ) u_lane (
      .ad9361_dclk (ad9361_dclk),
      .sys_nrst    (sys_nrst),
      .i_half      (ad9361_din[I_HI:I_LO]),
      .q_half      (ad9361_din[Q_HI:Q_LO]),
      .msb_we      (beat_idx == CNT_W'(2 * c)),
      .lsb_we      (beat_idx == CNT_W'(2 * c + 1)),
      .out_we      (out_we),
      .rx_i        (rx_i_w[c*OUT_W +: OUT_W]),
      .rx_q        (rx_q_w[c*OUT_W +: OUT_W])
    );
  end

  assign rx.rx_i = rx_i_w;
  assign rx.rx_q = rx_q_w;

`ifdef AD9361_RX_FRAME_ERR_EN
  logic        err_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge ad9361_dclk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_evt;
      if (err_evt && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign frame_err     = err_q;
  assign frame_err_cnt = err_cnt_q;
`else
  logic unused_err_evt;

  assign unused_err_evt = err_evt;
  assign frame_err      = 1'b0;
  assign frame_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_ad9361_rx_deframer.sv
// tb/tb_ad9361_rx_deframer.sv - scoreboard bench for 1R1T (sign/zero extend) and 2R2T deframer builds
module tb_ad9361_rx_deframer;

  logic        clk;
  logic        nrst;
  logic [13:0] din_a;
  logic [13:0] din_c;
  logic        locked_a, locked_b, locked_c;
  logic        err_a, err_b, err_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  int          checks;
  int          failures;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [63:0] q_c[$];
  logic [31:0] mon_a, mon_b;
  logic [63:0] mon_c;
  logic [15:0] last_a_i;
  logic        exp_err;
  logic [15:0] exp_cnt;

  ad9361_rx_deframer_if #(.NUM_CH(1), .OUT_W(16)) rx_a ();
  ad9361_rx_deframer_if #(.NUM_CH(1), .OUT_W(16)) rx_b ();
  ad9361_rx_deframer_if #(.NUM_CH(2), .OUT_W(16)) rx_c ();

  ad9361_rx_deframer #(.NUM_CH(1), .SAMPLE_W(12), .OUT_W(16), .SIGN_EXT(1), .LOCK_FRAMES(4)) u_a (
    .ad9361_dclk(clk), .sys_nrst(nrst), .ad9361_din(din_a), .rx(rx_a),
    .locked(locked_a), .frame_err(err_a), .frame_err_cnt(cnt_a));

  ad9361_rx_deframer #(.NUM_CH(1), .SAMPLE_W(12), .OUT_W(16), .SIGN_EXT(0), .LOCK_FRAMES(4)) u_b (
    .ad9361_dclk(clk), .sys_nrst(nrst), .ad9361_din(din_a), .rx(rx_b),
    .locked(locked_b), .frame_err(err_b), .frame_err_cnt(cnt_b));

  ad9361_rx_deframer #(.NUM_CH(2), .SAMPLE_W(12), .OUT_W(16), .SIGN_EXT(1), .LOCK_FRAMES(4)) u_c (
    .ad9361_dclk(clk), .sys_nrst(nrst), .ad9361_din(din_c), .rx(rx_c),
    .locked(locked_c), .frame_err(err_c), .frame_err_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sx(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic logic [15:0] zx(input logic [11:0] v);
    return {4'h0, v};
  endfunction

  function automatic logic [13:0] w(input logic f, input logic [5:0] ih, input logic [5:0] qh);
    return {f, ih, 1'b1, qh};
  endfunction

  always @(negedge clk) begin
    if (rx_a.rx_valid === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_valid got i=%h q=%h required no strobe", rx_a.rx_i, rx_a.rx_q);
      end else begin
        mon_a = q_a.pop_front();
        if ({rx_a.rx_i, rx_a.rx_q} !== mon_a) begin
          failures++;
          $display("FAIL a_sample got %h required %h", {rx_a.rx_i, rx_a.rx_q}, mon_a);
        end
      end
    end
    if (rx_b.rx_valid === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_valid got i=%h q=%h required no strobe", rx_b.rx_i, rx_b.rx_q);
      end else begin
        mon_b = q_b.pop_front();
        if ({rx_b.rx_i, rx_b.rx_q} !== mon_b) begin
          failures++;
          $display("FAIL b_sample got %h required %h", {rx_b.rx_i, rx_b.rx_q}, mon_b);
        end
      end
    end
    if (rx_c.rx_valid === 1'b1) begin
      checks++;
      if (q_c.size() == 0) begin
        failures++;
        $display("FAIL c_unexpected_valid got i=%h q=%h required no strobe", rx_c.rx_i, rx_c.rx_q);
      end else begin
        mon_c = q_c.pop_front();
        if ({rx_c.rx_i, rx_c.rx_q} !== mon_c) begin
          failures++;
          $display("FAIL c_sample got %h required %h", {rx_c.rx_i, rx_c.rx_q}, mon_c);
        end
      end
    end
  end

  task automatic beat(input logic [13:0] va, input logic [13:0] vc);
    din_a = va;
    din_c = vc;
    @(negedge clk);
  endtask

  task automatic frame_a(input logic [11:0] i, input logic [11:0] q, input bit expect_out);
    if (expect_out) begin
      q_a.push_back({sx(i), sx(q)});
      q_b.push_back({zx(i), zx(q)});
      last_a_i = sx(i);
    end
    beat(w(1'b1, i[11:6], q[11:6]), '0);
    beat(w(1'b0, i[5:0], q[5:0]), '0);
  endtask

  task automatic frame_c(input logic [11:0] i0, input logic [11:0] q0,
                         input logic [11:0] i1, input logic [11:0] q1, input bit expect_out);
    if (expect_out) q_c.push_back({sx(i1), sx(i0), sx(q1), sx(q0)});
    beat('0, w(1'b1, i0[11:6], q0[11:6]));
    beat('0, w(1'b1, i0[5:0], q0[5:0]));
    beat('0, w(1'b0, i1[11:6], q1[11:6]));
    beat('0, w(1'b0, i1[5:0], q1[5:0]));
  endtask

  task automatic do_reset;
    nrst  = 1'b0;
    din_a = '0;
    din_c = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({rx_a.rx_i, rx_a.rx_q, rx_a.rx_valid, locked_a, err_a, cnt_a} !== 51'd0) begin
      failures++;
      $display("FAIL reset_a got %h required 0", {rx_a.rx_i, rx_a.rx_q, rx_a.rx_valid, locked_a, err_a, cnt_a});
    end
    checks++;
    if ({rx_c.rx_i, rx_c.rx_q, rx_c.rx_valid, locked_c, err_c, cnt_c} !== 83'd0) begin
      failures++;
      $display("FAIL reset_c got %h required 0", {rx_c.rx_i, rx_c.rx_q, rx_c.rx_valid, locked_c, err_c, cnt_c});
    end
    nrst = 1'b1;
    repeat (3) beat('0, '0);
    checks++;
    if ({locked_a, locked_b, locked_c} !== 3'b000) begin
      failures++;
      $display("FAIL idle_no_lock got %b required 000", {locked_a, locked_b, locked_c});
    end
  endtask

  task automatic test_lock_n1;
    do_reset;
    for (int k = 1; k <= 6; k++) begin
      frame_a(12'hA5C, 12'h123, k >= 5);
      if (k == 3) begin
        checks++;
        if (locked_a !== 1'b0) begin
          failures++;
          $display("FAIL lock_early got %b required 0", locked_a);
        end
      end
      if (k == 4) begin
        checks++;
        if ({locked_a, locked_b} !== 2'b11) begin
          failures++;
          $display("FAIL lock_after_4 got %b required 11", {locked_a, locked_b});
        end
      end
    end
    beat('0, '0);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL lock_n1_missing_valid got %0d/%0d pending required 0", q_a.size(), q_b.size());
    end
    checks++;
    if ({rx_a.rx_i, rx_a.rx_q} !== 32'hFA5C_0123) begin
      failures++;
      $display("FAIL sext_hold got %h required fa5c0123", {rx_a.rx_i, rx_a.rx_q});
    end
    checks++;
    if ({rx_b.rx_i, rx_b.rx_q} !== 32'h0A5C_0123) begin
      failures++;
      $display("FAIL zext_hold got %h required 0a5c0123", {rx_b.rx_i, rx_b.rx_q});
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_two_ch;
    do_reset;
    for (int k = 1; k <= 6; k++) begin
      frame_c(12'h7FF, 12'h3C1, 12'h800, 12'h9AB, k >= 5);
      if (k == 4) begin
        checks++;
        if (locked_c !== 1'b1) begin
          failures++;
          $display("FAIL lock_2ch got %b required 1", locked_c);
        end
      end
    end
    beat('0, '0);
    checks++;
    if (q_c.size() != 0) begin
      failures++;
      $display("FAIL two_ch_missing_valid got %0d pending required 0", q_c.size());
    end
    checks++;
    if (rx_c.rx_i !== 32'hF800_07FF) begin
      failures++;
      $display("FAIL two_ch_rx_i got %h required f80007ff", rx_c.rx_i);
    end
    q_c.delete();
  endtask

  task automatic test_frame_err;
`ifdef AD9361_RX_FRAME_ERR_EN
    exp_err = 1'b1;
    exp_cnt = 16'd1;
`else
    exp_err = 1'b0;
    exp_cnt = 16'd0;
`endif
    do_reset;
    for (int k = 1; k <= 5; k++) frame_a(12'($urandom), 12'($urandom), k == 5);
    beat(w(1'b1, 6'h15, 6'h2A), '0);
    beat(w(1'b1, 6'h0F, 6'h30), '0);
    checks++;
    if ({err_a, cnt_a, locked_a} !== {exp_err, exp_cnt, 1'b0}) begin
      failures++;
      $display("FAIL err_pulse got err=%b cnt=%h locked=%b required err=%b cnt=%h locked=0",
               err_a, cnt_a, locked_a, exp_err, exp_cnt);
    end
    checks++;
    if (rx_a.rx_i !== last_a_i) begin
      failures++;
      $display("FAIL hold_after_err got %h required %h", rx_a.rx_i, last_a_i);
    end
    beat('0, '0);
    checks++;
    if ({err_a, cnt_a} !== {1'b0, exp_cnt}) begin
      failures++;
      $display("FAIL err_one_cycle got err=%b cnt=%h required err=0 cnt=%h", err_a, cnt_a, exp_cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      frame_a(12'($urandom), 12'($urandom), k == 5);
      if (k == 3 || k == 4) begin
        checks++;
        if (locked_a !== (k == 4)) begin
          failures++;
          $display("FAIL relock_frame%0d got %b required %b", k, locked_a, k == 4);
        end
      end
    end
    beat('0, '0);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL relock_missing_valid got %0d/%0d pending required 0", q_a.size(), q_b.size());
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic test_err_saturation;
    do_reset;
`ifdef AD9361_RX_FRAME_ERR_EN
    force u_a.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u_a.err_cnt_q;
    exp_err = 1'b1;
    exp_cnt = 16'hFFFF;
`else
    exp_err = 1'b0;
    exp_cnt = 16'h0000;
`endif
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) frame_a(12'($urandom), 12'($urandom), 1'b0);
      beat(w(1'b1, 6'h01, 6'h02), '0);
      beat(w(1'b1, 6'h03, 6'h04), '0);
      checks++;
      if ({err_a, cnt_a, locked_a} !== {exp_err, exp_cnt, 1'b0}) begin
        failures++;
        $display("FAIL sat_err%0d got err=%b cnt=%h locked=%b required err=%b cnt=%h locked=0",
                 n, err_a, cnt_a, locked_a, exp_err, exp_cnt);
      end
      beat('0, '0);
    end
  endtask

  task automatic test_reset_midframe;
    do_reset;
    for (int k = 1; k <= 5; k++) frame_a(12'($urandom), 12'($urandom), k == 5);
    beat(w(1'b1, 6'h3F, 6'h3F), '0);
    din_a = w(1'b0, 6'h3F, 6'h3F);
    nrst  = 1'b0;
    #1;
    checks++;
    if ({rx_a.rx_i, rx_a.rx_q, rx_a.rx_valid, locked_a, err_a, cnt_a, rx_b.rx_i, locked_b} !== 68'd0) begin
      failures++;
      $display("FAIL async_reset got %h required 0",
               {rx_a.rx_i, rx_a.rx_q, rx_a.rx_valid, locked_a, err_a, cnt_a, rx_b.rx_i, locked_b});
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    beat('0, '0);
    for (int k = 1; k <= 5; k++) begin
      frame_a(12'($urandom), 12'($urandom), k == 5);
      if (k == 4) begin
        checks++;
        if ({locked_a, rx_a.rx_i} !== {1'b1, 16'h0000}) begin
          failures++;
          $display("FAIL post_reset_relock got locked=%b i=%h required locked=1 i=0000", locked_a, rx_a.rx_i);
        end
      end
    end
    beat('0, '0);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL post_reset_missing_valid got %0d/%0d pending required 0", q_a.size(), q_b.size());
    end
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    din_a    = '0;
    din_c    = '0;
    last_a_i = '0;
    exp_err  = 1'b0;
    exp_cnt  = '0;
    test_reset;
    test_lock_n1;
    test_two_ch;
    test_frame_err;
    test_err_saturation;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
